// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the operand-pair arbiter in front of a streaming adder.
package adder_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Tag width is $clog2(num_req), kept at least 1 bit so a tag signal always exists.
  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TAG_W   = tag_width(DEF_NUM_REQ);

endpackage

// File: rtl/adder_arbiter_tag_fifo.sv
// Tag queue recording which requester owns each in-flight sum, oldest at the head.
module adder_arbiter_tag_fifo #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              empty_s;
  logic              full_s;
  logic              push_en_s;
  logic              pop_en_s;

  // The count MSB is set only at exactly DEPTH entries.
  assign empty_s   = (count_r == {(ADDR_W+1){1'b0}});
  assign full_s    = count_r[ADDR_W];
  assign pop_en_s  = pop_i && !empty_s;
  assign push_en_s = push_i && (!full_s || pop_en_s);

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk_i) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1'b1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1'b1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + (ADDR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (ADDR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data_o = mem_r[rd_ptr_r];
  assign empty_o    = empty_s;
  assign full_o     = full_s;
  assign count_o    = count_r;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding operand pairs to a shared adder and routing sums back by tag.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_REQ       = 4,
  parameter int TAG_FIFO_SIZE = 3
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic [NUM_REQ*WIDTH-1:0] req_opa_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_opb_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]         rsp_sum_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         add_opa_o,
  output logic [WIDTH-1:0]         add_opb_o,
  output logic                     add_opa_valid_o,
  output logic                     add_opb_valid_o,
  input  logic                     add_opa_ready_i,
  input  logic                     add_opb_ready_i,
  input  logic [WIDTH-1:0]         add_sum_i,
  input  logic                     add_sum_valid_i,
  output logic                     add_sum_ready_o,
  output logic [TAG_FIFO_SIZE:0]   outstanding_o,
  output logic                     error_o
);

  localparam int TAG_W = tag_width(NUM_REQ);

  state_e              state_r, state_s;
  logic [TAG_W-1:0]    grant_r, grant_s;
  logic [TAG_W-1:0]    rr_r, rr_s, rr_inc_s;
  logic                opa_done_r, opa_done_s;
  logic                opb_done_r, opb_done_s;
  logic                error_r;
  logic                found_s;
  logic [TAG_W-1:0]    pick_s;
  int                  idx_s;
  int                  inc_s;
  logic                issue_s;
  logic                opa_fire_s;
  logic                opb_fire_s;
  logic                pair_done_s;
  logic                push_s;
  logic                pop_s;
  logic                sum_ok_s;
  logic [TAG_W-1:0]    head_s;
  logic                tag_empty_s;
  logic                tag_full_s;
  logic [TAG_FIFO_SIZE:0] tag_count_s;
  logic [NUM_REQ-1:0]  one_s;

  assign one_s = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // First valid requester at or above the round-robin pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {TAG_W{1'b0}};
    idx_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = int'(rr_r) + i;
      idx_s = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
      if (!found_s && req_valid_i[TAG_W'(idx_s)]) begin
        found_s = 1'b1;
        pick_s  = TAG_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign inc_s    = int'(grant_r) + 1;
  assign rr_inc_s = (inc_s >= NUM_REQ) ? {TAG_W{1'b0}} : TAG_W'(inc_s);

  // Output gating on arst_ni keeps every handshake quiet while reset is held.
  assign issue_s     = arst_ni && (state_r == ST_ISSUE);
  assign opa_fire_s  = issue_s && !opa_done_r && add_opa_ready_i;
  assign opb_fire_s  = issue_s && !opb_done_r && add_opb_ready_i;
  assign pair_done_s = issue_s && (opa_done_r || opa_fire_s) && (opb_done_r || opb_fire_s);

  // Next-state logic for the IDLE/ISSUE arbitration FSM.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_s       = rr_r;
    opa_done_s = opa_done_r;
    opb_done_s = opb_done_r;
    push_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && !tag_full_s) begin
          grant_s = pick_s;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (pair_done_s) begin
          push_s     = 1'b1;
          rr_s       = rr_inc_s;
          opa_done_s = 1'b0;
          opb_done_s = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          opa_done_s = opa_done_r || opa_fire_s;
          opb_done_s = opb_done_r || opb_fire_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, grant, pointer and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_r    <= ST_IDLE;
      grant_r    <= {TAG_W{1'b0}};
      rr_r       <= {TAG_W{1'b0}};
      opa_done_r <= 1'b0;
      opb_done_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      rr_r       <= rr_s;
      opa_done_r <= opa_done_s;
      opb_done_r <= opb_done_s;
      error_r    <= error_r || (add_sum_valid_i && tag_empty_s);
    end
  end

  adder_arbiter_tag_fifo #(
    .DATA_W (TAG_W),
    .ADDR_W (TAG_FIFO_SIZE)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_ni      (arst_ni),
    .push_i      (push_s),
    .push_data_i (grant_r),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .empty_o     (tag_empty_s),
    .full_o      (tag_full_s),
    .count_o     (tag_count_s)
  );

  assign add_opa_o       = req_opa_i[grant_r*WIDTH +: WIDTH];
  assign add_opb_o       = req_opb_i[grant_r*WIDTH +: WIDTH];
  assign add_opa_valid_o = issue_s && !opa_done_r;
  assign add_opb_valid_o = issue_s && !opb_done_r;
  assign req_ready_o     = pair_done_s ? (one_s << grant_r) : {NUM_REQ{1'b0}};

  // A sum without an outstanding tag is never accepted; it only raises error_o.
  assign sum_ok_s        = arst_ni && !tag_empty_s;
  assign rsp_sum_o       = add_sum_i;
  assign rsp_valid_o     = (add_sum_valid_i && sum_ok_s) ? (one_s << head_s) : {NUM_REQ{1'b0}};
  assign add_sum_ready_o = sum_ok_s && rsp_ready_i[head_s];
  assign pop_s           = add_sum_valid_i && add_sum_ready_o;
  assign outstanding_o   = arst_ni ? tag_count_s : {(TAG_FIFO_SIZE+1){1'b0}};
  assign error_o         = error_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with hand-computed expected values.
module tb_adder_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [31:0] req_opa_i;
  logic [31:0] req_opb_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [7:0]  rsp_sum_o;
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i;
  logic [7:0]  add_opa_o;
  logic [7:0]  add_opb_o;
  logic        add_opa_valid_o;
  logic        add_opb_valid_o;
  logic        add_opa_ready_i;
  logic        add_opb_ready_i;
  logic [7:0]  add_sum_i;
  logic        add_sum_valid_i;
  logic        add_sum_ready_o;
  logic [3:0]  outstanding_o;
  logic        error_o;

  int vectors = 0;
  int miscompares = 0;

  adder_arbiter #(.WIDTH(8), .NUM_REQ(4), .TAG_FIFO_SIZE(3)) dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .req_opa_i       (req_opa_i),
    .req_opb_i       (req_opb_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .rsp_sum_o       (rsp_sum_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .add_opa_o       (add_opa_o),
    .add_opb_o       (add_opb_o),
    .add_opa_valid_o (add_opa_valid_o),
    .add_opb_valid_o (add_opb_valid_o),
    .add_opa_ready_i (add_opa_ready_i),
    .add_opb_ready_i (add_opb_ready_i),
    .add_sum_i       (add_sum_i),
    .add_sum_valid_i (add_sum_valid_i),
    .add_sum_ready_o (add_sum_ready_o),
    .outstanding_o   (outstanding_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
    req_opa_i[k*8 +: 8] = a;
    req_opb_i[k*8 +: 8] = b;
  endtask

  task automatic do_reset();
    arst_ni         = 1'b0;
    req_valid_i     = 4'h0;
    rsp_ready_i     = 4'h0;
    add_sum_valid_i = 1'b0;
    add_sum_i       = 8'h00;
    tick();
    tick();
    arst_ni = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_opa_valid"}, 32'(add_opa_valid_o), 32'h0);
    chk({tag, "_opb_valid"}, 32'(add_opb_valid_o), 32'h0);
    chk({tag, "_sum_ready"}, 32'(add_sum_ready_o), 32'h0);
    chk({tag, "_outstanding"}, 32'(outstanding_o), 32'h0);
  endtask

  logic [7:0] exp_sum [4];
  int         order [5];

  initial begin
    exp_sum = '{8'h11, 8'h22, 8'h33, 8'h44};
    order   = '{0, 1, 2, 3, 0};
    req_opa_i = 32'h0;
    req_opb_i = 32'h0;
    add_opa_ready_i = 1'b1;
    add_opb_ready_i = 1'b1;

    // Reset state
    arst_ni = 1'b0;
    req_valid_i = 4'h0; rsp_ready_i = 4'h0; add_sum_valid_i = 1'b0; add_sum_i = 8'h00;
    tick(); tick();
    chk_quiet("rst");
    chk("rst_error", 32'(error_o), 32'h0);
    arst_ni = 1'b1;

    // Single pair from requester 1: 0x12 + 0x34
    set_req(1, 8'h12, 8'h34);
    req_valid_i = 4'b0010;
    #1;
    chk("t1_idle_opa_valid", 32'(add_opa_valid_o), 32'h0);
    tick(); #1;
    chk("t1_opa", 32'(add_opa_o), 32'h12);
    chk("t1_opb", 32'(add_opb_o), 32'h34);
    chk("t1_opa_valid", 32'(add_opa_valid_o), 32'h1);
    chk("t1_req_ready", 32'(req_ready_o), 32'h2);
    tick();
    req_valid_i = 4'h0;
    #1;
    chk("t1_outstanding1", 32'(outstanding_o), 32'h1);
    chk("t1_req_ready_off", 32'(req_ready_o), 32'h0);
    add_sum_i = 8'h46; add_sum_valid_i = 1'b1; rsp_ready_i = 4'b0010;
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid_o), 32'h2);
    chk("t1_rsp_sum", 32'(rsp_sum_o), 32'h46);
    chk("t1_sum_ready", 32'(add_sum_ready_o), 32'h1);
    tick();
    add_sum_valid_i = 1'b0; rsp_ready_i = 4'h0;
    #1;
    chk("t1_outstanding0", 32'(outstanding_o), 32'h0);

    // All four valid from reset: grant order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 8'(8'h10 * (k + 1)), 8'(k + 1));
    req_valid_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick(); #1;
      chk($sformatf("t2_grant%0d", g), 32'(req_ready_o), 32'(4'b0001 << order[g]));
      chk($sformatf("t2_opa%0d", g), 32'(add_opa_o), 32'(8'h10 * (order[g] + 1)));
      tick();
    end
    req_valid_i = 4'h0;
    #1;
    chk("t2_outstanding5", 32'(outstanding_o), 32'h5);
    rsp_ready_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      add_sum_valid_i = 1'b1;
      add_sum_i = exp_sum[order[g]];
      #1;
      chk($sformatf("t2_rsp_valid%0d", g), 32'(rsp_valid_o), 32'(4'b0001 << order[g]));
      chk($sformatf("t2_rsp_sum%0d", g), 32'(rsp_sum_o), 32'(exp_sum[order[g]]));
      tick();
    end
    add_sum_valid_i = 1'b0; rsp_ready_i = 4'h0;
    #1;
    chk("t2_outstanding0", 32'(outstanding_o), 32'h0);

    // Wrap-around sum returned to requester 2
    set_req(2, 8'hFF, 8'h02);
    req_valid_i = 4'b0100;
    tick(); #1;
    chk("t3_req_ready", 32'(req_ready_o), 32'h4);
    chk("t3_opa", 32'(add_opa_o), 32'hFF);
    tick();
    req_valid_i = 4'h0;
    add_sum_i = 8'h01; add_sum_valid_i = 1'b1; rsp_ready_i = 4'b0100;
    #1;
    chk("t3_rsp_valid", 32'(rsp_valid_o), 32'h4);
    chk("t3_rsp_sum", 32'(rsp_sum_o), 32'h01);
    tick();
    add_sum_valid_i = 1'b0; rsp_ready_i = 4'h0;

    // Operand B stalled three cycles while A is accepted at once
    set_req(3, 8'h05, 8'h06);
    add_opb_ready_i = 1'b0;
    req_valid_i = 4'b1000;
    tick(); #1;
    chk("t4_c1_opa_valid", 32'(add_opa_valid_o), 32'h1);
    chk("t4_c1_opb_valid", 32'(add_opb_valid_o), 32'h1);
    chk("t4_c1_req_ready", 32'(req_ready_o), 32'h0);
    for (int c = 2; c <= 3; c++) begin
      tick(); #1;
      chk($sformatf("t4_c%0d_opa_valid", c), 32'(add_opa_valid_o), 32'h0);
      chk($sformatf("t4_c%0d_opb_valid", c), 32'(add_opb_valid_o), 32'h1);
      chk($sformatf("t4_c%0d_req_ready", c), 32'(req_ready_o), 32'h0);
    end
    tick();
    add_opb_ready_i = 1'b1;
    #1;
    chk("t4_c4_opa_valid", 32'(add_opa_valid_o), 32'h0);
    chk("t4_c4_req_ready", 32'(req_ready_o), 32'h8);
    tick();
    req_valid_i = 4'h0;
    #1;
    chk("t4_after_req_ready", 32'(req_ready_o), 32'h0);
    chk("t4_after_opb_valid", 32'(add_opb_valid_o), 32'h0);
    chk("t4_outstanding", 32'(outstanding_o), 32'h1);
    add_sum_i = 8'h0B; add_sum_valid_i = 1'b1; rsp_ready_i = 4'b1000;
    #1;
    chk("t4_rsp_valid", 32'(rsp_valid_o), 32'h8);
    tick();
    add_sum_valid_i = 1'b0; rsp_ready_i = 4'h0;

    // Fill the tag queue: 9th pair held off until a pop
    set_req(0, 8'h01, 8'h01);
    req_valid_i = 4'b0001;
    for (int p = 0; p < 8; p++) begin
      tick();
      tick();
    end
    #1;
    chk("t5_outstanding8", 32'(outstanding_o), 32'h8);
    tick(); #1;
    chk("t5_full_opa_valid", 32'(add_opa_valid_o), 32'h0);
    chk("t5_full_req_ready", 32'(req_ready_o), 32'h0);
    add_sum_i = 8'h02; add_sum_valid_i = 1'b1; rsp_ready_i = 4'b0001;
    #1;
    chk("t5_sum_ready", 32'(add_sum_ready_o), 32'h1);
    chk("t5_rsp_valid", 32'(rsp_valid_o), 32'h1);
    tick();
    add_sum_valid_i = 1'b0; rsp_ready_i = 4'h0;
    #1;
    chk("t5_pop_cycle_opa_valid", 32'(add_opa_valid_o), 32'h0);
    chk("t5_outstanding7", 32'(outstanding_o), 32'h7);
    tick(); #1;
    chk("t5_resume_opa_valid", 32'(add_opa_valid_o), 32'h1);
    chk("t5_resume_req_ready", 32'(req_ready_o), 32'h1);

    // Orphan sum sets the sticky error
    do_reset();
    add_sum_i = 8'h55; add_sum_valid_i = 1'b1;
    #1;
    chk("t6_sum_ready", 32'(add_sum_ready_o), 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid_o), 32'h0);
    tick();
    add_sum_valid_i = 1'b0;
    #1;
    chk("t6_error_set", 32'(error_o), 32'h1);
    tick(); #1;
    chk("t6_error_sticky", 32'(error_o), 32'h1);

    // Reset in the middle of an issue
    add_opa_ready_i = 1'b0; add_opb_ready_i = 1'b0;
    set_req(2, 8'h21, 8'h22);
    req_valid_i = 4'b0100;
    tick(); #1;
    chk("t7_issue_opa_valid", 32'(add_opa_valid_o), 32'h1);
    arst_ni = 1'b0;
    #1;
    chk_quiet("t7_in_rst");
    tick(); #1;
    chk_quiet("t7_after_edge");
    chk("t7_error_cleared", 32'(error_o), 32'h0);
    arst_ni = 1'b1;
    add_opa_ready_i = 1'b1; add_opb_ready_i = 1'b1;
    set_req(0, 8'h03, 8'h04);
    req_valid_i = 4'b0101;
    tick(); #1;
    chk("t7_regrant", 32'(req_ready_o), 32'h1);
    chk("t7_regrant_opa", 32'(add_opa_o), 32'h03);
    tick();
    req_valid_i = 4'h0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum bit width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (>=2).
REQ-003 SHALL have parameter TAG_FIFO_SIZE, default 3, log2 depth of the tag queue (max outstanding pairs).
REQ-004 SHALL have ports: clk_i  in  1  clock; one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports: arst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
REQ-006 SHALL have ports: req_opa_i / req_opb_i  in  NUM_REQ x WIDTH  per-requester operand pair.
REQ-007 SHALL have ports: req_valid_i  in  NUM_REQ, and req_ready_o  out  NUM_REQ, pair handshake.
REQ-008 SHALL have ports: rsp_sum_o  out  WIDTH, shared sum; rsp_valid_o  out  NUM_REQ; rsp_ready_i  in  NUM_REQ.
REQ-009 SHALL have ports: add_opa_o / add_opb_o  out  WIDTH; add_opa_valid_o / add_opb_valid_o  out  1; add_opa_ready_i / add_opb_ready_i  in  1, to the adder datapath operand ports.
REQ-010 SHALL have ports: add_sum_i  in  WIDTH; add_sum_valid_i  in  1; add_sum_ready_o  out  1, from adder datapath.
REQ-011 SHALL have ports: outstanding_o  out  TAG_FIFO_SIZE+1, pairs issued without returned sum; error_o  out  1, sticky protocol error.

Function
REQ-012 SHALL implement FSM IDLE/ISSUE; IDLE: if any req_valid_i and tag queue not full, register grant = first valid index searching from rr pointer upward (mod NUM_REQ), go ISSUE next cycle.
REQ-013 SHALL, in ISSUE, drive add_opa_o/add_opb_o from granted requester; add_opa_valid_o = !opa_done, add_opb_valid_o = !opb_done.
REQ-014 SHALL set opa_done/opb_done on each accepted add handshake; each operand transferred exactly once per pair, independently.
REQ-015 SHALL declare pair complete in the cycle both operands are transferred (done flag or same-cycle fire); req_ready_o[grant] = 1 in that cycle only, all other req_ready_o = 0.
REQ-016 SHALL on completion push grant index to tag queue, set rr pointer = grant+1 mod NUM_REQ, clear done flags, return to IDLE.
REQ-017 SHALL require requesters to hold req_valid_i and operands stable until req_ready_o; grant is never revoked in ISSUE.
REQ-018 SHALL assert rsp_valid_o[k] only when add_sum_valid_i, tag queue non-empty and tag head == k; rsp_sum_o = add_sum_i combinationally.
REQ-019 SHALL drive add_sum_ready_o = tag non-empty && rsp_ready_i[tag head]; pop tag on that handshake.
REQ-020 SHALL handle simultaneous push and pop in one cycle; outstanding_o unchanged.
REQ-021 SHALL not grant when tag queue full (outstanding_o == 2^TAG_FIFO_SIZE); resume the cycle after a pop.
REQ-022 SHALL, if add_sum_valid_i with tag queue empty, keep add_sum_ready_o = 0 and set error_o until reset.
REQ-023 SHALL pass sums unmodified; wrap-around is the datapath's (mod 2^WIDTH).
REQ-024 SHALL take 1 cycle arbitration latency; max issue rate one pair per 2 cycles.

Reset
REQ-025 SHALL on arst_ni low at clk_i edge: state IDLE, rr pointer 0, done flags 0, tag queue empty, error_o 0.
REQ-026 SHALL hold all req_ready_o, rsp_valid_o, add_*_valid_o, add_sum_ready_o at 0, outstanding_o 0 during reset.
REQ-027 SHALL, on reset mid-ISSUE, abandon the partial pair; datapath shares the reset so no orphan sums return.

Structure
REQ-028 SHALL place state enum and tag-width constant ($clog2(NUM_REQ)) in package adder_arbiter_pkg.
REQ-029 SHALL implement tag queue as sub-module adder_arbiter_tag_fifo (synchronous reset, count output).

Verification
REQ-030 SHALL verify: req 1 sends 0x12/0x34 -> rsp_valid_o[1] with rsp_sum_o 0x46; other rsp_valid_o 0; outstanding_o 1 -> 0.
REQ-031 SHALL verify: all 4 requesters valid from reset -> grant order 0,1,2,3,0; sums return in that order to matching ports.
REQ-032 SHALL verify: 0xFF+0x02 -> 0x01 on requester's response port.
REQ-033 SHALL verify: add_opa_ready_i 1, add_opb_ready_i 0 for 3 cycles -> add_opa_valid_o drops after 1 accept, opb held, single req_ready_o pulse on opb accept.
REQ-034 SHALL verify: rsp_ready_i all 0, 8 pairs issued -> 9th not granted, outstanding_o 8; one rsp_ready_i -> grant resumes.
REQ-035 SHALL verify: add_sum_valid_i with empty queue -> error_o 1 sticky, add_sum_ready_o 0; reset mid-ISSUE -> all outputs 0, next grant from requester 0.
